// File: rtl/coeff_pingpong_ram_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ntru_mem_pkg : shared constants, FSM state type and helpers for  |
// |                the ping-pong coefficient memory                  |
// | Revision     : 1.0                                               |
// +------------------------------------------------------------------+
package ntru_mem_pkg;

  localparam int c_RAM_WIDTH     = 13;
  localparam int c_RAM_ADDR_BITS = 11;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } mem_state_t;

  // Narrowest index that still addresses every used word of a bank.
  function automatic int idx_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/coeff_pingpong_ram_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | coeff_pingpong_ram_if : producer/consumer/control bundle of the  |
// |                         ping-pong coefficient memory             |
// | Revision              : 1.0                                      |
// +------------------------------------------------------------------+
interface coeff_pingpong_ram_if
  import ntru_mem_pkg::*;
#(
  parameter int RAM_WIDTH     = c_RAM_WIDTH,
  parameter int RAM_ADDR_BITS = c_RAM_ADDR_BITS
);

  logic                     i_wr_en;
  logic [RAM_ADDR_BITS-1:0] i_wr_addr;
  logic [RAM_WIDTH-1:0]     i_wr_data;
  logic [RAM_ADDR_BITS-1:0] i_rd_addr;
  logic [RAM_WIDTH-1:0]     o_rd_data;
  logic                     i_swap_req;
  logic                     o_swap_ack;
  logic                     i_clr_req;
  logic                     o_clr_busy;
  logic                     o_clr_done;
  logic                     o_wr_bank;
  logic                     o_wr_drop;

  modport slave (
    input  i_wr_en, i_wr_addr, i_wr_data, i_rd_addr, i_swap_req, i_clr_req,
    output o_rd_data, o_swap_ack, o_clr_busy, o_clr_done, o_wr_bank, o_wr_drop
  );

  modport master (
    output i_wr_en, i_wr_addr, i_wr_data, i_rd_addr, i_swap_req, i_clr_req,
    input  o_rd_data, o_swap_ack, o_clr_busy, o_clr_done, o_wr_bank, o_wr_drop
  );

endinterface
`default_nettype wire

// File: rtl/coeff_pingpong_ram_bank.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dist_ram_bank : one coefficient bank, 1 write + 1 read port;     |
// |                 read is registered when NGEN_RD_REG_EN is set    |
// | Revision      : 1.0                                              |
// +------------------------------------------------------------------+
module dist_ram_bank #(
  parameter int WIDTH = 13,
  parameter int IDX_W = 10,
  parameter int DEPTH = 761
) (
  input  wire logic             clk,
  input  wire logic             i_we,
  input  wire logic [IDX_W-1:0] i_waddr,
  input  wire logic [WIDTH-1:0] i_wdata,
  input  wire logic [IDX_W-1:0] i_raddr,
  output logic      [WIDTH-1:0] o_rdata
);

`ifdef NGEN_RD_REG_EN
  (* ram_style = "block" *) logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // No reset on the output register so the bank maps onto block RAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
`else
  (* ram_style = "distributed" *) logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];
`endif

endmodule
`default_nettype wire

// File: rtl/coeff_pingpong_ram.sv
`default_nettype none
// +------------------------------------------------------------------+
// | coeff_pingpong_ram : double-buffered coefficient memory with     |
// |                      swap control and write-bank clear engine;   |
// |                      NGEN_RD_REG_EN selects registered read data |
// | Revision           : 1.0                                         |
// +------------------------------------------------------------------+
module coeff_pingpong_ram
  import ntru_mem_pkg::*;
#(
  parameter int                   RAM_WIDTH     = c_RAM_WIDTH,
  parameter int                   RAM_ADDR_BITS = c_RAM_ADDR_BITS,
  parameter int                   DEPTH         = 2 ** RAM_ADDR_BITS,
  parameter logic [RAM_WIDTH-1:0] CLR_VAL       = '0
) (
  input wire logic            clk,
  input wire logic            rst,
  coeff_pingpong_ram_if.slave bus
);

  localparam int                       c_IDX_W = idx_bits(DEPTH);
  localparam logic [RAM_ADDR_BITS:0]   c_DEPTH = (RAM_ADDR_BITS + 1)'(DEPTH);
  localparam logic [RAM_ADDR_BITS-1:0] c_LAST  = RAM_ADDR_BITS'(DEPTH - 1);
  localparam logic [RAM_ADDR_BITS-1:0] c_ONE   = RAM_ADDR_BITS'(1);

  mem_state_t               r_state;
  logic                     r_wr_bank;
  logic                     r_clr_bank;
  logic                     r_swap_pend;
  logic                     r_swap_ack;
  logic                     r_clr_done;
  logic                     r_wr_drop;
  logic [RAM_ADDR_BITS-1:0] r_cnt;

  logic                     w_clearing;
  logic                     w_last;
  logic                     w_wr_in_rng;
  logic                     w_rd_in_rng;
  logic                     w_port_we;
  logic                     w_clr_we;
  logic                     w_swap_now;
  logic                     w_bank_nxt;
  logic [RAM_ADDR_BITS-1:0] w_cnt_inc;
  logic [c_IDX_W-1:0]       w_waddr;
  logic [c_IDX_W-1:0]       w_ridx;
  logic [RAM_WIDTH-1:0]     w_wdata;
  logic [RAM_WIDTH-1:0]     w_bank_rdata [2];

  assign w_clearing  = (r_state == CLEAR);
  assign w_last      = w_clearing && (r_cnt == c_LAST);
  assign w_cnt_inc   = r_cnt + c_ONE;
  assign w_wr_in_rng = ({1'b0, bus.i_wr_addr} < c_DEPTH);
  assign w_rd_in_rng = ({1'b0, bus.i_rd_addr} < c_DEPTH);

  // Writes are gated by rst so a clear interrupted by reset stops exactly at its count.
  assign w_port_we = bus.i_wr_en && w_wr_in_rng && !w_clearing && !rst;
  assign w_clr_we  = w_clearing && !rst;

  // A deferred swap fires on the edge that leaves CLEAR, so its ack lands in the first IDLE cycle.
  assign w_swap_now = w_clearing ? (w_last && (r_swap_pend || bus.i_swap_req))
                                 : bus.i_swap_req;
  assign w_bank_nxt = r_wr_bank ^ w_swap_now;

  assign w_waddr = w_clearing ? r_cnt[c_IDX_W-1:0] : bus.i_wr_addr[c_IDX_W-1:0];
  assign w_wdata = w_clearing ? CLR_VAL : bus.i_wr_data;
  assign w_ridx  = bus.i_rd_addr[c_IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_wr_bank   <= 1'b0;
      r_clr_bank  <= 1'b0;
      r_swap_pend <= 1'b0;
      r_swap_ack  <= 1'b0;
      r_clr_done  <= 1'b0;
      r_wr_drop   <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_wr_bank  <= w_bank_nxt;
      r_swap_ack <= w_swap_now;
      r_clr_done <= 1'b0;
      r_wr_drop  <= bus.i_wr_en && (w_clearing || !w_wr_in_rng);
      case (r_state)
        IDLE: begin
          if (bus.i_clr_req) begin
            r_state    <= CLEAR;
            r_cnt      <= '0;
            r_clr_bank <= w_bank_nxt;
            r_clr_done <= (DEPTH == 1);
          end
        end
        CLEAR: begin
          if (w_last) begin
            r_state     <= IDLE;
            r_swap_pend <= 1'b0;
          end else begin
            r_cnt       <= w_cnt_inc;
            r_clr_done  <= (w_cnt_inc == c_LAST);
            r_swap_pend <= r_swap_pend || bus.i_swap_req;
          end
        end
      endcase
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic w_we;

    assign w_we = (w_clr_we  && (r_clr_bank == 1'(b))) ||
                  (w_port_we && (r_wr_bank  == 1'(b)));

    dist_ram_bank #(
      .WIDTH (RAM_WIDTH),
      .IDX_W (c_IDX_W),
      .DEPTH (DEPTH)
    ) u_bank (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_raddr (w_ridx),
      .o_rdata (w_bank_rdata[b])
    );
  end

`ifdef NGEN_RD_REG_EN
  logic r_rd_sel;
  logic r_rd_ok;

  // Bank select and range flag travel with the address through the read register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_sel <= 1'b0;
      r_rd_ok  <= 1'b0;
    end else begin
      r_rd_sel <= ~r_wr_bank;
      r_rd_ok  <= w_rd_in_rng;
    end
  end

  assign bus.o_rd_data = r_rd_ok ? w_bank_rdata[r_rd_sel] : '0;
`else
  assign bus.o_rd_data = w_rd_in_rng ? w_bank_rdata[~r_wr_bank] : '0;
`endif

  assign bus.o_swap_ack = r_swap_ack;
  assign bus.o_clr_busy = w_clearing;
  assign bus.o_clr_done = r_clr_done;
  assign bus.o_wr_bank  = r_wr_bank;
  assign bus.o_wr_drop  = r_wr_drop;

endmodule
`default_nettype wire

// File: tb/tb_coeff_pingpong_ram.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_coeff_pingpong_ram : scoreboard bench for coeff_pingpong_ram  |
// | Revision              : 1.0                                      |
// +------------------------------------------------------------------+
module tb_coeff_pingpong_ram;

  localparam int W     = 13;
  localparam int AB    = 11;
  localparam int DEPTH = 761;
`ifdef NGEN_RD_REG_EN
  localparam bit REG_RD = 1'b1;
`else
  localparam bit REG_RD = 1'b0;
`endif

  typedef struct packed {
    logic [AB-1:0] addr;
    logic [W-1:0]  data;
  } rd_exp_t;

  logic    clk = 1'b0;
  logic    rst;
  logic    rd_issue   = 1'b0;
  logic    rd_issue_q = 1'b0;
  rd_exp_t q[$];
  rd_exp_t m_e;
  int      checks = 0;
  int      errors = 0;
  int      n_busy, done_at, acks;

  always #5 clk = ~clk;

  coeff_pingpong_ram_if #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB)) bus ();

  coeff_pingpong_ram #(
    .RAM_WIDTH     (W),
    .RAM_ADDR_BITS (AB),
    .DEPTH         (DEPTH),
    .CLR_VAL       (13'h0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(posedge clk) rd_issue_q <= rd_issue;

  // Read monitor: pops the expected word whenever read data is due.
  always @(negedge clk) begin
    if (REG_RD ? rd_issue_q : rd_issue) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL rd_underflow act=data_due exp=queued_entry");
      end else begin
        m_e = q.pop_front();
        if (bus.o_rd_data !== m_e.data) begin
          errors++;
          $display("FAIL rd_data addr=%0d act=%0h exp=%0h", m_e.addr, bus.o_rd_data, m_e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    bus.i_wr_en    = 1'b0;
    bus.i_swap_req = 1'b0;
    bus.i_clr_req  = 1'b0;
    rd_issue       = 1'b0;
  endtask

  task automatic issue_rd(input logic [AB-1:0] a, input logic [W-1:0] e);
    bus.i_rd_addr = a;
    rd_issue      = 1'b1;
    q.push_back({a, e});
  endtask

  task automatic rd(input logic [AB-1:0] a, input logic [W-1:0] e);
    issue_rd(a, e);
    step();
  endtask

  task automatic wr(input logic [AB-1:0] a, input logic [W-1:0] d);
    bus.i_wr_en   = 1'b1;
    bus.i_wr_addr = a;
    bus.i_wr_data = d;
    step();
  endtask

  // Walks a clear to completion; mode 0 injects swap/write/clr traffic, mode 1 reads the read bank.
  task automatic run_clear(input int mode, output int nb, output int da, output int na);
    nb = 0;
    da = -1;
    na = 0;
    for (int i = 0; i < DEPTH + 20 && bus.o_clr_busy; i++) begin
      nb++;
      if (bus.o_clr_done) da = i;
      if (bus.o_swap_ack) na++;
      if (mode == 0) begin
        if (i == 100 || i == 150) bus.i_swap_req = 1'b1;
        if (i == 120) chk("t3_bank_held", 32'(bus.o_wr_bank), 1);
        if (i == 200) begin
          bus.i_wr_en   = 1'b1;
          bus.i_wr_addr = 11'd7;
          bus.i_wr_data = 13'h0055;
        end
        if (i == 201) chk("t4_drop_in_clear", 32'(bus.o_wr_drop), 1);
        if (i == 300) issue_rd(11'd5, 13'h1ABC);
        if (i == 400) bus.i_clr_req = 1'b1;
      end else begin
        if (i == 10) issue_rd(11'd300, 13'h0333);
        if (i == 20) issue_rd(11'd500, 13'h0444);
        if (i == 30) issue_rd(11'd760, 13'h0555);
        if (i == 40) issue_rd(11'd5, 13'h0000);
      end
      step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst            = 1'b1;
    bus.i_wr_en    = 1'b0;
    bus.i_wr_addr  = '0;
    bus.i_wr_data  = '0;
    bus.i_rd_addr  = 11'd761;
    bus.i_swap_req = 1'b0;
    bus.i_clr_req  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_swap_ack", 32'(bus.o_swap_ack), 0);
    chk("rst_clr_busy", 32'(bus.o_clr_busy), 0);
    chk("rst_clr_done", 32'(bus.o_clr_done), 0);
    chk("rst_wr_bank",  32'(bus.o_wr_bank),  0);
    chk("rst_wr_drop",  32'(bus.o_wr_drop),  0);
    chk("rst_rd_data",  32'(bus.o_rd_data),  0);
    rst = 1'b0;
    step();

    // Write, swap, read back from the now-read bank
    wr(11'd5, 13'h1ABC);
    chk("t1_no_drop", 32'(bus.o_wr_drop), 0);
    bus.i_swap_req = 1'b1;
    step();
    chk("t1_swap_ack", 32'(bus.o_swap_ack), 1);
    chk("t1_wr_bank",  32'(bus.o_wr_bank),  1);
    rd(11'd5, 13'h1ABC);
    chk("t1_ack_pulse", 32'(bus.o_swap_ack), 0);
    rd(11'd761, 13'h0000);
    rd(11'd2047, 13'h0000);

    // Out-of-range write is dropped
    wr(11'd761, 13'h1FFF);
    chk("t4_drop_oor", 32'(bus.o_wr_drop), 1);
    step();
    chk("t4_drop_pulse", 32'(bus.o_wr_drop), 0);

    // Fill bank 1 with non-zero data, then clear it with a deferred swap
    wr(11'd0,   13'h0123);
    wr(11'd7,   13'h0777);
    wr(11'd300, 13'h0AAA);
    wr(11'd760, 13'h1FFF);
    bus.i_clr_req = 1'b1;
    step();
    run_clear(0, n_busy, done_at, acks);
    chk("t2_busy_cycles",  32'(n_busy),  761);
    chk("t2_done_at",      32'(done_at), 760);
    chk("t3_no_ack_clear", 32'(acks),    0);
    chk("t3_ack_after",    32'(bus.o_swap_ack), 1);
    chk("t3_bank_toggled", 32'(bus.o_wr_bank),  0);
    step();
    chk("t3_single_ack",   32'(bus.o_swap_ack), 0);
    chk("t3_bank_once",    32'(bus.o_wr_bank),  0);
    for (int a = 0; a < DEPTH; a++) rd(AB'(a), 13'h0000);

    // Reset in the middle of clearing bank 0
    wr(11'd0,   13'h0111);
    wr(11'd299, 13'h0222);
    wr(11'd300, 13'h0333);
    wr(11'd500, 13'h0444);
    wr(11'd760, 13'h0555);
    bus.i_clr_req = 1'b1;
    step();
    for (int i = 0; i < 300; i++) begin
      if (i == 50) bus.i_swap_req = 1'b1;
      step();
    end
    rst = 1'b1;
    step();
    chk("t5_clr_busy", 32'(bus.o_clr_busy), 0);
    chk("t5_clr_done", 32'(bus.o_clr_done), 0);
    chk("t5_swap_ack", 32'(bus.o_swap_ack), 0);
    chk("t5_wr_drop",  32'(bus.o_wr_drop),  0);
    chk("t5_wr_bank",  32'(bus.o_wr_bank),  0);
    rst = 1'b0;
    step();
    chk("t5_no_pend_ack", 32'(bus.o_swap_ack), 0);
    chk("t5_idle",        32'(bus.o_clr_busy), 0);
    bus.i_swap_req = 1'b1;
    step();
    chk("t5_swap_ack2", 32'(bus.o_swap_ack), 1);
    chk("t5_wr_bank2",  32'(bus.o_wr_bank),  1);
    rd(11'd0,   13'h0000);
    rd(11'd5,   13'h0000);
    rd(11'd299, 13'h0000);
    rd(11'd300, 13'h0333);
    rd(11'd500, 13'h0444);
    rd(11'd760, 13'h0555);

    // Simultaneous swap and clear: the new write bank is cleared
    wr(11'd10,  13'h0A0A);
    wr(11'd760, 13'h1234);
    bus.i_swap_req = 1'b1;
    step();
    chk("t6_pre_bank", 32'(bus.o_wr_bank), 0);
    rd(11'd10, 13'h0A0A);
    bus.i_swap_req = 1'b1;
    bus.i_clr_req  = 1'b1;
    step();
    chk("t6_wr_bank", 32'(bus.o_wr_bank),  1);
    chk("t6_ack",     32'(bus.o_swap_ack), 1);
    chk("t6_busy",    32'(bus.o_clr_busy), 1);
    run_clear(1, n_busy, done_at, acks);
    chk("t6_busy_cycles", 32'(n_busy),  761);
    chk("t6_done_at",     32'(done_at), 760);
    chk("t6_acks",        32'(acks),    1);
    chk("t6_bank_kept",   32'(bus.o_wr_bank), 1);
    rd(11'd500, 13'h0444);
    bus.i_swap_req = 1'b1;
    step();
    chk("t6_final_bank", 32'(bus.o_wr_bank), 0);
    rd(11'd10,  13'h0000);
    rd(11'd760, 13'h0000);

    step();
    step();
    chk("sb_empty", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
